// File: rtl/act_sigmoid_tansig.sv
// act_sigmoid_tansig: pipelined float32 tanh / logistic-sigmoid activation unit.
//
// Three register stages, one sample per cycle, no backpressure:
//   S1  unpack float, halve the argument for sigmoid, convert |arg| to unsigned fixed point
//   S2  tanh by 129-entry table lookup with linear interpolation
//   S3  fold in sign / sigmoid offset, normalise and pack back to float32 (mantissa truncated)
// sigmoid(x) is evaluated as 0.5 + 0.5 * tanh(x / 2).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data and mode are valid this cycle
//   in_data    operand x, float32
//   mode       0 = tanh, 1 = sigmoid, travels with its sample
//   out_valid  out_data is valid this cycle (three cycles after in_valid)
//   out_data   result, float32; holds its last value while out_valid is low
module act_sigmoid_tansig #(
  parameter int unsigned FLOAT     = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [FLOAT-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  output logic [FLOAT-1:0] out_data
);

  // |arg| < 8 once saturation is split off, so the top integer bit is never stored.
  localparam int unsigned FixW    = FRAC_BITS + 3;
  localparam int unsigned LutW    = FRAC_BITS + 1;
  localparam int unsigned InterpW = FRAC_BITS - 4;
  // Combined magnitude in U1.(FRAC_BITS+1): one extra fraction bit holds 0.5 * t exactly.
  localparam int unsigned VW      = FRAC_BITS + 2;
  localparam int unsigned LutN    = 129;

  // Builds T[k] = round(tanh(k/16) * 2^FRAC_BITS) at elaboration time.
  // tanh(x) = (1 - E) / (1 + E) with E = exp(-2x) = exp(-1/8)^k, all in Q60 integers.
  function automatic logic [LutN*LutW-1:0] gen_tanh_rom();
    logic [127:0]           one, term, r, e, num, den, q;
    logic [LutN*LutW-1:0]   rom;
    one  = 128'd1 << 60;
    term = one;
    r    = one;
    for (int n = 1; n < 24; n++) begin
      term = term / 128'(8 * n);
      if (n % 2 == 1) r = r - term;
      else            r = r + term;
    end
    e   = one;
    rom = '0;
    for (int k = 0; k < int'(LutN); k++) begin
      num = (one - e) << (FRAC_BITS + 1);
      den = one + e;
      q   = num / den;
      rom[k*LutW +: LutW] = LutW'((q + 128'd1) >> 1);
      e = (e * r) >> 60;
    end
    return rom;
  endfunction

  localparam logic [LutN*LutW-1:0] TanhRom = gen_tanh_rom();

  // ---------------------------------------------------------------- S1: unpack
  logic [8:0]      ee;
  logic [8:0]      rsh;
  logic            s1_zero, s1_nan, s1_sat;
  logic [FixW-1:0] fix_d;

  always_comb begin
    // Sigmoid halves the argument by dropping one from the exponent.
    ee      = {1'b0, in_data[30:23]} - {8'b0, mode};
    s1_nan  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    s1_zero = (in_data[30:23] == 8'h00) || (ee == 9'd0);
    // Unbiased exponent >= 3 means |arg| >= 8; Inf lands here too.
    s1_sat  = !s1_zero && (ee >= 9'd130);
    // Right shift that places the hidden-one mantissa on the fixed-point grid.
    rsh     = 9'(150 - FRAC_BITS) - ee;
    fix_d   = '0;
    if (!s1_zero && !s1_sat && (rsh < 9'd24)) begin
      fix_d = FixW'({1'b1, in_data[22:0]} >> rsh);
    end
  end

  logic            v1_q, md1_q, sg1_q, nan1_q, sat1_q;
  logic [FixW-1:0] fix1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      md1_q  <= 1'b0;
      sg1_q  <= 1'b0;
      nan1_q <= 1'b0;
      sat1_q <= 1'b0;
      fix1_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        md1_q  <= mode;
        sg1_q  <= in_data[31];
        nan1_q <= s1_nan;
        sat1_q <= s1_sat;
        fix1_q <= fix_d;
      end
    end
  end

  // ---------------------------------------------------------------- S2: evaluate
  logic [LutW-1:0] lut [LutN];

  for (genvar g = 0; g < int'(LutN); g++) begin : g_lut
    assign lut[g] = TanhRom[g*LutW +: LutW];
  end

  logic [6:0]              k_idx;
  logic [InterpW-1:0]      frac;
  logic [LutW-1:0]         t0, t1, diff, t_d;
  logic [LutW+InterpW-1:0] prod;

  always_comb begin
    k_idx = fix1_q[FixW-1 -: 7];
    frac  = fix1_q[InterpW-1:0];
    t0    = lut[{1'b0, k_idx}];
    t1    = lut[{1'b0, k_idx} + 8'd1];
    diff  = t1 - t0;
    prod  = {{LutW{1'b0}}, frac} * {{InterpW{1'b0}}, diff};
    if (sat1_q) t_d = {1'b1, {FRAC_BITS{1'b0}}};
    else        t_d = t0 + LutW'(prod >> InterpW);
  end

  logic            v2_q, md2_q, sg2_q, nan2_q;
  logic [LutW-1:0] t2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      md2_q  <= 1'b0;
      sg2_q  <= 1'b0;
      nan2_q <= 1'b0;
      t2_q   <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        md2_q  <= md1_q;
        sg2_q  <= sg1_q;
        nan2_q <= nan1_q;
        t2_q   <= t_d;
      end
    end
  end

  // ---------------------------------------------------------------- S3: combine and pack
  localparam logic [VW-1:0] Half = {2'b01, {FRAC_BITS{1'b0}}};

  logic [VW-1:0]    mag;
  logic             sgn;
  logic [4:0]       lead;
  logic [22:0]      mant;
  logic [7:0]       expo;
  logic [FLOAT-1:0] res;

  always_comb begin
    sgn = 1'b0;
    if (nan2_q) begin
      mag = md2_q ? Half : '0;
    end else if (md2_q) begin
      mag = sg2_q ? (Half - {1'b0, t2_q}) : (Half + {1'b0, t2_q});
    end else begin
      mag = {t2_q, 1'b0};
      sgn = sg2_q;
    end

    lead = '0;
    for (int i = 0; i < int'(VW); i++) begin
      if (mag[i]) lead = 5'(i);
    end
    // Shifting the leading one up to bit 23 pushes it out of the field, leaving the mantissa.
    mant = 23'(mag) << (5'd23 - lead);
    expo = 8'(128 - VW) + {3'b0, lead};

    if (mag == '0) res = '0;
    else           res = {sgn, expo, mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= v2_q;
      if (v2_q) out_data <= res;
    end
  end

endmodule

// File: tb/tb_act_sigmoid_tansig.sv
module tb_act_sigmoid_tansig;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  act_sigmoid_tansig #(
    .FLOAT     (32),
    .FRAC_BITS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Expected-output scoreboard, one entry per issued sample.
  logic [31:0] q_x[$];
  logic        q_md[$];
  int          q_cyc[$];
  int          q_kind[$];   // 0: exact word, 1: within 2^-10 of q_ref
  logic [31:0] q_word[$];
  real         q_ref[$];
  int          q_slot[$];

  logic [31:0] sweep_res [2][1281];

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    n_total++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp,
               tol);
    end
  endtask

  function automatic real dec(input logic [31:0] w);
    real r;
    if (w[30:23] == 8'd0) return 0.0;
    r = (8388608.0 + real'(w[22:0])) * $pow(2.0, real'(int'(w[30:23]) - 150));
    return w[31] ? -r : r;
  endfunction

  // Float32 encoding of k * 2^-fb (exact for small k).
  function automatic logic [31:0] enc(input int k, input int fb);
    int          n, p;
    logic [31:0] w;
    if (k == 0) return 32'h0;
    n = (k < 0) ? -k : k;
    p = 0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    w[31]    = (k < 0);
    w[30:23] = 8'(127 + p - fb);
    w[22:0]  = 23'(n << (23 - p));
    return w;
  endfunction

  function automatic real ref_f(input real x, input logic md);
    return md ? 1.0 / (1.0 + $exp(-x)) : $tanh(x);
  endfunction

  function automatic longint fx(input real r);
    return longint'(r * 1048576.0);
  endfunction

  // One clock: observe the output at the falling edge, then drive the next input.
  task automatic tick(input logic v, input logic [31:0] x, input logic md, input int kind,
                      input logic [31:0] word, input real refv, input int slot);
    logic [31:0] p_x, p_word;
    logic        p_md;
    int          p_cyc, p_kind, p_slot;
    real         p_ref;
    @(negedge clk);
    cyc++;
    if (out_valid) begin
      if (q_x.size() == 0) begin
        check("spurious_out_valid", 1, 0, 0);
      end else begin
        p_x = q_x.pop_front();     p_md = q_md.pop_front();     p_cyc = q_cyc.pop_front();
        p_kind = q_kind.pop_front(); p_word = q_word.pop_front(); p_ref = q_ref.pop_front();
        p_slot = q_slot.pop_front();
        check($sformatf("latency x=%h", p_x), cyc - p_cyc, 3, 0);
        if (p_kind == 0)
          check($sformatf("word m=%0d x=%h", p_md, p_x), out_data, p_word, 0);
        else
          check($sformatf("acc m=%0d x=%h", p_md, p_x), fx(dec(out_data)), fx(p_ref), 1024);
        if (p_slot >= 0) sweep_res[p_md][p_slot] = out_data;
      end
    end
    in_valid = v;
    in_data  = x;
    mode     = md;
    if (v) begin
      q_x.push_back(x);     q_md.push_back(md);     q_cyc.push_back(cyc);
      q_kind.push_back(kind); q_word.push_back(word); q_ref.push_back(refv);
      q_slot.push_back(slot);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 0, 32'h0, 0.0, -1);
  endtask

  task automatic send_exact(input logic [31:0] x, input logic md, input logic [31:0] word);
    tick(1'b1, x, md, 0, word, 0.0, -1);
  endtask

  task automatic send_tol(input logic [31:0] x, input logic md, input real refv, input int slot);
    tick(1'b1, x, md, 1, 32'h0, refv, slot);
  endtask

  task automatic clear_q();
    q_x.delete(); q_md.delete(); q_cyc.delete(); q_kind.delete();
    q_word.delete(); q_ref.delete(); q_slot.delete();
  endtask

  initial begin
    int          viol;
    logic [31:0] x;
    logic        md;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_out_data", out_data, 0, 0);
    rst_n = 1'b1;

    // Zeros, isolated then back to back
    send_exact(32'h00000000, 1'b0, 32'h00000000);
    idle(4);
    send_exact(32'h80000000, 1'b0, 32'h00000000);
    send_exact(32'h00000000, 1'b1, 32'h3F000000);
    send_exact(32'h80000000, 1'b1, 32'h3F000000);

    // Saturation and specials
    send_exact(32'h41200000, 1'b0, 32'h3F800000);  // tanh(10)
    send_exact(32'hFF800000, 1'b0, 32'hBF800000);  // tanh(-Inf)
    send_exact(32'h7F800000, 1'b0, 32'h3F800000);  // tanh(+Inf)
    send_exact(32'h41000000, 1'b0, 32'h3F800000);  // tanh(8) boundary
    send_exact(32'hC1000000, 1'b0, 32'hBF800000);  // tanh(-8) boundary
    send_exact(32'h41A00000, 1'b1, 32'h3F800000);  // sigmoid(20)
    send_exact(32'hC1A00000, 1'b1, 32'h00000000);  // sigmoid(-20)
    send_exact(32'h41800000, 1'b1, 32'h3F800000);  // sigmoid(16) boundary
    send_exact(32'hC1800000, 1'b1, 32'h00000000);  // sigmoid(-16) boundary
    send_exact(32'h7FC00000, 1'b0, 32'h00000000);  // NaN
    send_exact(32'h7FC00000, 1'b1, 32'h3F000000);
    send_exact(32'h00000001, 1'b0, 32'h00000000);  // denormal
    send_exact(32'h00000001, 1'b1, 32'h3F000000);

    // Known points
    send_tol(32'h3F000000, 1'b0, 0.46212, -1);     // tanh(0.5)
    send_tol(32'h3F800000, 1'b1, 0.73106, -1);     // sigmoid(1.0)
    idle(5);
    check("drain_directed", q_x.size(), 0, 0);

    // Accuracy sweep -10..10 step 1/64, both modes, back to back
    for (int m = 0; m < 2; m++) begin
      for (int k = -640; k <= 640; k++) begin
        send_tol(enc(k, 6), 1'(m), ref_f(real'(k) / 64.0, 1'(m)), k + 640);
      end
    end
    idle(5);
    check("drain_sweep", q_x.size(), 0, 0);

    viol = 0;
    for (int k = 1; k <= 640; k++) begin
      if (sweep_res[0][640 + k] != (sweep_res[0][640 - k] ^ 32'h80000000)) viol++;
    end
    check("tanh_symmetry_violations", viol, 0, 0);
    for (int m = 0; m < 2; m++) begin
      viol = 0;
      for (int k = 0; k < 1280; k++) begin
        if (dec(sweep_res[m][k + 1]) < dec(sweep_res[m][k])) viol++;
      end
      check($sformatf("monotonic_violations m=%0d", m), viol, 0, 0);
    end

    // Streaming: alternating mode with random bubbles
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      x  = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 133)), 23'($urandom)};
      md = 1'(i % 2);
      send_tol(x, md, ref_f(dec(x), md), -1);
    end
    idle(5);
    check("drain_stream", q_x.size(), 0, 0);

    // Reset with three samples in flight
    send_exact(32'h41200000, 1'b0, 32'h3F800000);
    send_exact(32'h41200000, 1'b0, 32'h3F800000);
    send_exact(32'h41200000, 1'b0, 32'h3F800000);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0, 0);
    check("midrst_out_data", out_data, 0, 0);
    clear_q();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("post_rst_out_valid", out_valid, 0, 0);
    end
    check("post_rst_out_data", out_data, 0, 0);

    // New traffic after reset still works
    send_exact(32'hC1200000, 1'b0, 32'hBF800000);
    idle(5);
    check("drain_final", q_x.size(), 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
